// File: rtl/if_fetch_unit_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, queue sizing and
// the address alignment helper used by the fetch unit.
package if_fetch_unit_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {instruction, next_pc} pairs between the memory
// port and the IF/ID register. Flush empties it on the next edge.
module fetch_queue
  import if_fetch_unit_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [31:0]      push_ins_i,
  input  logic [31:0]      push_next_pc_i,
  output logic [CNT_W-1:0] count_o,
  output logic [31:0]      head_ins_o,
  output logic [31:0]      head_next_pc_o
);

  logic [31:0]      ins_q     [FIFO_DEPTH];
  logic [31:0]      next_pc_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; only the pointers and count define occupancy.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      ins_q[wr_ptr_q]     <= push_ins_i;
      next_pc_q[wr_ptr_q] <= push_next_pc_i;
    end
  end

  assign count_o        = count_q;
  assign head_ins_o     = ins_q[rd_ptr_q];
  assign head_next_pc_o = next_pc_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// 2-entry queue, with redirect handling that drains a stale request in DROP.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_ins,
  output logic [31:0] out_next_pc
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      drop_addr_q, drop_addr_d;
  logic             req, push, pop;
  logic [31:0]      addr;
  logic [CNT_W-1:0] count;
  logic [31:0]      head_ins, head_next_pc;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    req         = 1'b0;
    addr        = pc_q;
    push        = 1'b0;
    case (state_q)
      FETCH: begin
        // Once raised, req cannot drop: count only falls until the transfer.
        req = (count < FIFO_FULL_CNT);
        if (req && imem_ack && !redirect) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
        end
        if (redirect) begin
          pc_d = word_align(redirect_pc);
          if (req && !imem_ack) begin
            state_d     = DROP;
            drop_addr_d = pc_q;
          end
        end
      end
      DROP: begin
        req  = 1'b1;
        addr = drop_addr_q;
        if (imem_ack) state_d = FETCH;
        if (redirect) pc_d = word_align(redirect_pc);
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    drop_addr_q <= drop_addr_d;
  end

  assign imem_req  = req && !reset;
  assign imem_addr = reset ? RESET_PC : addr;

  // A redirect hides the head so nothing stale is consumed before the flush.
  assign out_valid   = (count != '0) && !redirect && !reset;
  assign pop         = out_valid && !stall;
  assign out_ins     = out_valid ? head_ins : 32'h0;
  assign out_next_pc = out_valid ? head_next_pc : 32'h0;

  fetch_queue u_fetch_queue (
    .clk_i          (clk),
    .rst_i          (reset),
    .push_i         (push && !reset),
    .pop_i          (pop),
    .flush_i        (redirect),
    .push_ins_i     (imem_rdata),
    .push_next_pc_i (pc_q + 32'd4),
    .count_o        (count),
    .head_ins_o     (head_ins),
    .head_next_pc_o (head_next_pc)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a latency-configurable memory model,
// a pop scoreboard and directed scenarios for redirect, stall, wrap and reset.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] npc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_ins;
  logic [31:0] out_next_pc;

  int          ack_lat = 0;
  logic        ack_force = 1'b0;
  int          age = 0;
  logic        mon_keep = 1'b1;
  int          base = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [31:0] xfer_q[$];

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ins     (out_ins),
    .out_next_pc (out_next_pc)
  );

  always #5 clk = ~clk;

  // Memory acks once a request has waited ack_lat cycles; data is ~address.
  assign imem_ack   = ack_force | (imem_req && (age >= ack_lat));
  assign imem_rdata = ~imem_addr;

  always @(posedge clk) begin
    if (imem_req && !imem_ack) age <= age + 1;
    else age <= 0;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard: pops compared against earlier kept transfers, in order.
  always @(negedge clk) begin
    if (out_valid && !stall) begin
      check_eq("pop_has_exp", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("pop_ins", out_ins, e.ins);
        check_eq("pop_npc", out_next_pc, e.npc);
      end
    end
    if (imem_req && imem_ack && !reset) begin
      xfer_q.push_back(imem_addr);
      if (mon_keep) exp_q.push_back(exp_t'{ins: ~imem_addr, npc: imem_addr + 32'd4});
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scn(input int lat);
    reset     = 1'b1;
    redirect  = 1'b0;
    stall     = 1'b0;
    ack_force = 1'b0;
    mon_keep  = 1'b1;
    ack_lat   = lat;
    next_cyc();
    @(negedge clk);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, RST_PC);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ins", out_ins, 32'h0);
    check_eq("rst_npc", out_next_pc, 32'h0);
    next_cyc();
    reset = 1'b0;
    base  = xfer_q.size();
  endtask

  task automatic drain();
    ack_lat = 1000;
    repeat (3) next_cyc();
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Streaming fetch with ack every cycle
    start_scn(0);
    @(negedge clk);
    check_eq("s1_req0", 32'(imem_req), 32'd1);
    check_eq("s1_addr0", imem_addr, 32'h0000_0100);
    check_eq("s1_lat_valid", 32'(out_valid), 32'd0);
    next_cyc();
    @(negedge clk);
    check_eq("s1_addr1", imem_addr, 32'h0000_0104);
    check_eq("s1_valid1", 32'(out_valid), 32'd1);
    check_eq("s1_npc1", out_next_pc, 32'h0000_0104);
    check_eq("s1_ins1", out_ins, 32'hFFFF_FEFF);
    next_cyc();
    @(negedge clk);
    check_eq("s1_addr2", imem_addr, 32'h0000_0108);
    next_cyc();
    repeat (3) next_cyc();
    drain();
    check_eq("s1_log0", xfer_q[base], 32'h0000_0100);
    check_eq("s1_log1", xfer_q[base+1], 32'h0000_0104);
    check_eq("s1_log2", xfer_q[base+2], 32'h0000_0108);

    // Stall held: queue fills after two transfers, then releases in order
    start_scn(0);
    stall = 1'b1;
    next_cyc();
    next_cyc();
    @(negedge clk);
    check_eq("s2_full_req", 32'(imem_req), 32'd0);
    check_eq("s2_full_valid", 32'(out_valid), 32'd1);
    check_eq("s2_full_npc", out_next_pc, 32'h0000_0104);
    next_cyc();
    @(negedge clk);
    check_eq("s2_full_req2", 32'(imem_req), 32'd0);
    check_eq("s2_xfers", 32'(xfer_q.size() - base), 32'd2);
    next_cyc();
    stall = 1'b0;
    @(negedge clk);
    check_eq("s2_pop1_npc", out_next_pc, 32'h0000_0104);
    check_eq("s2_pop1_req", 32'(imem_req), 32'd0);
    next_cyc();
    @(negedge clk);
    check_eq("s2_resume_req", 32'(imem_req), 32'd1);
    check_eq("s2_resume_addr", imem_addr, 32'h0000_0108);
    check_eq("s2_pop2_npc", out_next_pc, 32'h0000_0108);
    next_cyc();
    drain();
    check_eq("s2_log2", xfer_q[base+2], 32'h0000_0108);

    // Late ack with redirect while waiting: stale data dropped
    start_scn(3);
    @(negedge clk);
    check_eq("s3_addr0", imem_addr, 32'h0000_0100);
    next_cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    mon_keep    = 1'b0;
    @(negedge clk);
    check_eq("s3_redir_valid", 32'(out_valid), 32'd0);
    next_cyc();
    redirect = 1'b0;
    @(negedge clk);
    check_eq("s3_drop_req", 32'(imem_req), 32'd1);
    check_eq("s3_drop_addr", imem_addr, 32'h0000_0100);
    next_cyc();
    @(negedge clk);
    check_eq("s3_drop_addr2", imem_addr, 32'h0000_0100);
    check_eq("s3_drop_valid", 32'(out_valid), 32'd0);
    next_cyc();
    mon_keep = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("s3_new_addr", imem_addr, 32'h0000_0200);
      check_eq("s3_wait_valid", 32'(out_valid), 32'd0);
      next_cyc();
    end
    @(negedge clk);
    check_eq("s3_valid", 32'(out_valid), 32'd1);
    check_eq("s3_npc", out_next_pc, 32'h0000_0204);
    next_cyc();
    drain();
    check_eq("s3_log0", xfer_q[base], 32'h0000_0100);
    check_eq("s3_log1", xfer_q[base+1], 32'h0000_0200);

    // Redirect to an unaligned target coincident with an ack
    start_scn(0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    mon_keep    = 1'b0;
    @(negedge clk);
    check_eq("s4_redir_valid", 32'(out_valid), 32'd0);
    next_cyc();
    redirect = 1'b0;
    mon_keep = 1'b1;
    @(negedge clk);
    check_eq("s4_addr", imem_addr, 32'h0000_0200);
    check_eq("s4_empty", 32'(out_valid), 32'd0);
    next_cyc();
    ack_lat = 1000;
    @(negedge clk);
    check_eq("s4_npc", out_next_pc, 32'h0000_0204);
    drain();

    // PC wrap from the top of the address space
    start_scn(0);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    mon_keep    = 1'b0;
    next_cyc();
    redirect = 1'b0;
    mon_keep = 1'b1;
    @(negedge clk);
    check_eq("s5_addr_top", imem_addr, 32'hFFFF_FFFC);
    next_cyc();
    @(negedge clk);
    check_eq("s5_addr_wrap", imem_addr, 32'h0000_0000);
    check_eq("s5_npc_wrap", out_next_pc, 32'h0000_0000);
    check_eq("s5_ins_top", out_ins, 32'h0000_0003);
    next_cyc();
    drain();

    // Reset during an outstanding request with ack in the reset cycle
    start_scn(2);
    next_cyc();
    next_cyc();
    reset     = 1'b1;
    ack_force = 1'b1;
    @(negedge clk);
    check_eq("s6_rst_req", 32'(imem_req), 32'd0);
    check_eq("s6_rst_addr", imem_addr, RST_PC);
    next_cyc();
    reset     = 1'b0;
    ack_force = 1'b0;
    ack_lat   = 1000;
    @(negedge clk);
    check_eq("s6_post_req", 32'(imem_req), 32'd1);
    check_eq("s6_post_addr", imem_addr, RST_PC);
    for (int i = 0; i < 3; i++) begin
      check_eq("s6_no_valid", 32'(out_valid), 32'd0);
      next_cyc();
      @(negedge clk);
    end
    check_eq("s6_xfers", 32'(xfer_q.size() - base), 32'd0);
    check_eq("sb_final", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
